// File: rtl/ghost_drop_scanner.sv
// ghost_drop_scanner: sequential hard-drop (ghost piece) landing calculator.
// A start pulse snapshots the active piece and the board; the scanner then
// tries one downward offset per cycle until a cell would leave the board or
// hit an occupied square, and reports the last legal offset.
// Optional build macro GHOST_SELF_MASK_EN: board bits that coincide with the
// piece's own original cells are ignored, so the board may contain the piece.
module ghost_drop_scanner #(
    parameter int WIDTH   = 10,
    parameter int HEIGHT  = 20,
    parameter int COORD_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [4*COORD_W-1:0]     piece_x,
    input  logic [4*COORD_W-1:0]     piece_y,
    input  logic [0:WIDTH*HEIGHT-1]  board,
    output logic                     busy,
    output logic                     done,
    output logic                     valid,
    output logic [COORD_W-1:0]       drop_dist,
    output logic [4*COORD_W-1:0]     ghost_y
);

    // state | meaning
    // IDLE  | waiting for start; last result held on the outputs
    // SCAN  | testing offset k_q against the snapshot, one offset per cycle

    localparam int CELLS = WIDTH * HEIGHT;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                 state_q, state_d;
    logic [4*COORD_W-1:0]   px_q, px_d;
    logic [4*COORD_W-1:0]   py_q, py_d;
    logic [0:CELLS-1]       board_q, board_d;
    logic [COORD_W-1:0]     k_q, k_d;
    logic                   done_q, done_d;
    logic                   valid_q, valid_d;
    logic [COORD_W-1:0]     drop_dist_q, drop_dist_d;
    logic [4*COORD_W-1:0]   ghost_y_q, ghost_y_d;

    logic                   collide;
    logic [COORD_W-1:0]     cx;
    logic [COORD_W:0]       yk;
    logic [IDX_W-1:0]       idx;
    logic                   masked;

    // Collision test for the current offset; sums carry one extra bit so a
    // large y can never wrap back onto the board.
    always_comb begin
        collide = 1'b0;
        cx      = '0;
        yk      = '0;
        idx     = '0;
        masked  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cx     = px_q[i*COORD_W +: COORD_W];
            yk     = {1'b0, py_q[i*COORD_W +: COORD_W]} + {1'b0, k_q};
            idx    = '0;
            masked = 1'b0;
            if (yk >= (COORD_W+1)'(HEIGHT) || cx >= COORD_W'(WIDTH)) begin
                collide = 1'b1;
            end else begin
                idx = IDX_W'(int'(yk) * WIDTH + int'(cx));
`ifdef GHOST_SELF_MASK_EN
                for (int j = 0; j < 4; j++) begin
                    if (yk == {1'b0, py_q[j*COORD_W +: COORD_W]} &&
                        cx == px_q[j*COORD_W +: COORD_W]) begin
                        masked = 1'b1;
                    end
                end
`endif
                if (board_q[idx] && !masked) begin
                    collide = 1'b1;
                end
            end
        end
    end

    // Next-state and result computation; results only move when done fires.
    always_comb begin
        state_d     = state_q;
        px_d        = px_q;
        py_d        = py_q;
        board_d     = board_q;
        k_d         = k_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        drop_dist_d = drop_dist_q;
        ghost_y_d   = ghost_y_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    px_d    = piece_x;
                    py_d    = piece_y;
                    board_d = board;
                    k_d     = COORD_W'(1);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (collide) begin
                    drop_dist_d = k_q - COORD_W'(1);
                    for (int i = 0; i < 4; i++) begin
                        ghost_y_d[i*COORD_W +: COORD_W] =
                            py_q[i*COORD_W +: COORD_W] + k_q - COORD_W'(1);
                    end
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    k_d = k_q + COORD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, snapshot and result registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            px_q        <= '0;
            py_q        <= '0;
            board_q     <= '0;
            k_q         <= '0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            drop_dist_q <= '0;
            ghost_y_q   <= '0;
        end else begin
            state_q     <= state_d;
            px_q        <= px_d;
            py_q        <= py_d;
            board_q     <= board_d;
            k_q         <= k_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            drop_dist_q <= drop_dist_d;
            ghost_y_q   <= ghost_y_d;
        end
    end

    assign busy      = (state_q == SCAN);
    assign done      = done_q;
    assign valid     = valid_q;
    assign drop_dist = drop_dist_q;
    assign ghost_y   = ghost_y_q;

endmodule

// File: tb/tb_ghost_drop_scanner.sv
// Bench for ghost_drop_scanner: a default 10x20 instance and a 6x8 instance,
// both checked against a per-column free-distance model.
module tb_ghost_drop_scanner;

    localparam int W  = 10;
    localparam int H  = 20;
    localparam int WS = 6;
    localparam int HS = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start = 1'b0, start_s = 1'b0;
    logic [39:0] piece_x = '0, piece_y = '0, px_s = '0, py_s = '0;
    logic [0:199] board = '0;
    logic [0:47]  board_s = '0;

    logic        busy, done, valid, busy_s, done_s, valid_s;
    logic [9:0]  drop_dist, drop_dist_s;
    logic [39:0] ghost_y, ghost_y_s;

    ghost_drop_scanner dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .piece_x(piece_x), .piece_y(piece_y), .board(board),
        .busy(busy), .done(done), .valid(valid),
        .drop_dist(drop_dist), .ghost_y(ghost_y)
    );

    ghost_drop_scanner #(.WIDTH(WS), .HEIGHT(HS), .COORD_W(10)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s),
        .piece_x(px_s), .piece_y(py_s), .board(board_s),
        .busy(busy_s), .done(done_s), .valid(valid_s),
        .drop_dist(drop_dist_s), .ghost_y(ghost_y_s)
    );

    bit sel = 1'b0;
    logic        done_m, busy_m, valid_m;
    logic [9:0]  dd_m;
    logic [39:0] gy_m;
    assign done_m  = sel ? done_s      : done;
    assign busy_m  = sel ? busy_s      : busy;
    assign valid_m = sel ? valid_s     : valid;
    assign dd_m    = sel ? drop_dist_s : drop_dist;
    assign gy_m    = sel ? ghost_y_s   : ghost_y;

    int n_vec = 0;
    int n_err = 0;
    int exp_drop [2] = '{0, 0};
    logic [39:0] exp_gy [2] = '{40'd0, 40'd0};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit own_cell(input logic [39:0] px, input logic [39:0] py, input int x, input int r);
        for (int j = 0; j < 4; j++)
            if (int'(px[j*10 +: 10]) == x && int'(py[j*10 +: 10]) == r) return 1'b1;
        return 1'b0;
    endfunction

    // Each cell can fall until the first blocked square in its column; the
    // piece falls by the smallest of those per-cell distances.
    function automatic int model_drop(input logic [39:0] px, input logic [39:0] py,
                                      input logic [0:199] b, input int w, input int h);
        int best, x, y, f;
        bit  blk;
        best = h;
        for (int i = 0; i < 4; i++) begin
            x = int'(px[i*10 +: 10]);
            y = int'(py[i*10 +: 10]);
            if (x >= w || y + 1 >= h) f = 0;
            else begin
                f = h - 1 - y;
                for (int r = y + 1; r < h; r++) begin
`ifdef GHOST_SELF_MASK_EN
                    blk = b[r*w + x] && !own_cell(px, py, x, r);
`else
                    blk = b[r*w + x];
`endif
                    if (blk) begin
                        f = r - y - 1;
                        break;
                    end
                end
            end
            if (f < best) best = f;
        end
        return best;
    endfunction

    function automatic logic [39:0] model_gy(input logic [39:0] py, input int d);
        logic [39:0] g;
        for (int i = 0; i < 4; i++) g[i*10 +: 10] = 10'(int'(py[i*10 +: 10]) + d);
        return g;
    endfunction

    task automatic scramble();
        piece_x = {$urandom, $urandom};
        piece_y = {$urandom, $urandom};
        px_s    = {$urandom, $urandom};
        py_s    = {$urandom, $urandom};
        for (int q = 0; q < 200; q++) board[q] = 1'($urandom_range(0, 1));
        for (int q = 0; q < 48; q++) board_s[q] = 1'($urandom_range(0, 1));
    endtask

    // Issues one start and follows it to done. With chain set, start is raised
    // in the same cycle the previous done is visible.
    task automatic run_scan(input bit sml, input bit chain, input logic [39:0] px,
                            input logic [39:0] py, input logic [0:199] b);
        int lat, d;
        bit got;
        if (!chain) @(negedge clk);
        sel = sml;
        if (sml) begin
            px_s = px; py_s = py; board_s = b[0:47]; start_s = 1'b1;
        end else begin
            piece_x = px; piece_y = py; board = b; start = 1'b1;
        end
        d   = model_drop(px, py, b, sml ? WS : W, sml ? HS : H);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(negedge clk);
            start = 1'b0;
            start_s = 1'b0;
            lat++;
            if (done_m) got = 1'b1;
            else begin
                chk("busy_in_scan", busy_m, 1);
                chk("hold_dist", dd_m, exp_drop[sml]);
                scramble();
            end
        end
        chk("latency", lat, d + 2);
        if (got) begin
            chk("drop_dist", dd_m, d);
            chk("ghost_y", gy_m, model_gy(py, d));
            chk("valid", valid_m, 1);
            chk("idle_at_done", busy_m, 0);
            exp_drop[sml] = d;
            exp_gy[sml]   = model_gy(py, d);
        end
    endtask

    task automatic check_pulse();
        @(negedge clk);
        chk("done_one_cycle", done_m, 0);
    endtask

    task automatic rand_piece(input int w, input int h, output logic [39:0] px, output logic [39:0] py);
        for (int i = 0; i < 4; i++) begin
            px[i*10 +: 10] = ($urandom_range(0, 9) == 0) ? 10'(w) : 10'($urandom_range(0, w - 1));
            py[i*10 +: 10] = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(h, 1023))
                                                          : 10'($urandom_range(0, h - 1));
        end
    endtask

    task automatic rand_board(input int w, input int h, output logic [0:199] b);
        b = '0;
        for (int q = 0; q < w * h; q++) b[q] = ($urandom_range(0, 7) == 0);
    endtask

    logic [39:0]  ipx, ipy, tpx, tpy;
    logic [0:199] tb_b;
    int ndone;
    bit ch;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        ipx = {10'd4, 10'd4, 10'd4, 10'd4};
        ipy = {10'd3, 10'd2, 10'd1, 10'd0};

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_valid", valid, 0);
        chk("rst_drop", drop_dist, 0);
        chk("rst_ghost", ghost_y, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // vertical I on an empty board
        run_scan(0, 0, ipx, ipy, '0);
        chk("I_drop16", drop_dist, 16);
        check_pulse();

        // O piece above an obstacle at (5,1)
        tb_b = '0;
        tb_b[5*10 + 1] = 1'b1;
        run_scan(0, 0, {10'd1, 10'd0, 10'd1, 10'd0}, {10'd1, 10'd1, 10'd0, 10'd0}, tb_b);
        chk("O_drop3", drop_dist, 3);
        check_pulse();

        // resting on the floor, then a start accepted in the done cycle
        run_scan(0, 0, {10'd2, 10'd2, 10'd2, 10'd2}, {10'd19, 10'd18, 10'd17, 10'd16}, '0);
        chk("floor_drop0", drop_dist, 0);
        run_scan(0, 1, ipx, ipy, '0);
        check_pulse();

        // second start during a scan is ignored
        @(negedge clk);
        sel = 1'b0;
        piece_x = ipx; piece_y = ipy; board = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 3) begin
                piece_x = {10'd0, 10'd0, 10'd0, 10'd0};
                piece_y = {10'd8, 10'd7, 10'd6, 10'd5};
                start = 1'b1;
            end else start = 1'b0;
            if (done) ndone++;
        end
        chk("one_done_per_start", ndone, 1);
        chk("busy_start_drop", drop_dist, 16);
        exp_drop[0] = 16;
        exp_gy[0]   = model_gy(ipy, 16);

        // self-masking: board already holds the piece
        tb_b = '0;
        for (int r = 0; r < 4; r++) tb_b[r*10 + 4] = 1'b1;
        run_scan(0, 0, ipx, ipy, tb_b);
`ifdef GHOST_SELF_MASK_EN
        chk("self_mask_drop", drop_dist, 16);
`else
        chk("self_mask_drop", drop_dist, 0);
`endif
        check_pulse();

        // small board, cell at x == WIDTH
        run_scan(1, 0, {10'd1, 10'd1, 10'd1, 10'd6}, {10'd3, 10'd2, 10'd1, 10'd0}, '0);
        chk("small_x_oob", drop_dist_s, 0);
        check_pulse();

        // randomized, default board
        ch = 1'b0;
        for (int it = 0; it < 40; it++) begin
            rand_piece(W, H, tpx, tpy);
            rand_board(W, H, tb_b);
            run_scan(0, ch, tpx, tpy, tb_b);
            ch = 1'($urandom_range(0, 1));
            if (!ch) check_pulse();
        end
        if (ch) check_pulse();

        // randomized, small board
        ch = 1'b0;
        for (int it = 0; it < 25; it++) begin
            rand_piece(WS, HS, tpx, tpy);
            rand_board(WS, HS, tb_b);
            run_scan(1, ch, tpx, tpy, tb_b);
            ch = 1'($urandom_range(0, 1));
            if (!ch) check_pulse();
        end
        if (ch) check_pulse();

        // reset in the middle of a scan
        sel = 1'b0;
        @(negedge clk);
        piece_x = ipx; piece_y = ipy; board = '0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_drop", drop_dist, 0);
        chk("mid_rst_ghost", ghost_y, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("no_done_after_rst", ndone, 0);
        exp_drop[0] = 0; exp_drop[1] = 0;
        exp_gy[0] = '0;  exp_gy[1] = '0;

        run_scan(0, 0, ipx, ipy, '0);
        check_pulse();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
